bcd_count_mod: RTL

- Parametrised, cascadable BCD modulo counter; successor to the fixed mod-10, mod-6 and mod-60 counters.
- Supports any modulus up to 10^NDIGITS, up/down direction, synchronous parallel load and terminal-count carry/borrow.
- Used for clock/timer digits: seconds and minutes (mod 60), hours (mod 24 or 12), and general mod-N display counters. Chains by tying co to the next stage's en.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_digit_updn.sv | 52 +++++
 rtl/bcd_count_mod.sv | 110 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Shared constants and helpers for the BCD counter family.
//   BCD_W     : width of one BCD digit.
//   bin2bcd   : converts a binary integer into packed BCD (up to 4 digits),
//               used to build the terminal-count constant at elaboration.
//   bcd_valid : 1 when every one of the low ndigits digits is 0..9.
package bcd_pkg;

  localparam int BCD_W    = 4;
  localparam int MAX_DIGS = 4;

  function automatic logic [MAX_DIGS*BCD_W-1:0] bin2bcd(input int value, input int ndigits);
    logic [MAX_DIGS*BCD_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGS; i++) begin
      if (i < ndigits) begin
        r[i*BCD_W +: BCD_W] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [MAX_DIGS*BCD_W-1:0] vec, input int ndigits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGS; i++) begin
      if ((i < ndigits) && (vec[i*BCD_W +: BCD_W] > 4'd9)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_updn.sv
// bcd_digit_updn
//   One registered BCD digit with up/down stepping.
//   clk, rst   : clock and synchronous active-high reset.
//   step       : advance this digit one position (lower digits wrapped).
//   up         : 1 = increment, 0 = decrement.
//   load, d    : parallel load of d.
//   force_zero : jump to 0 (counter wrap up / invalid-state recovery).
//   force_max  : jump to max_digit (counter wrap down / recovery).
//   q          : current digit value.
//   tc         : terminal digit for the current direction (9 up, 0 down).
module bcd_digit_updn
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             force_zero,
  input  logic             force_max,
  input  logic [BCD_W-1:0] max_digit,
  output logic [BCD_W-1:0] q,
  output logic             tc
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (force_zero) begin
      q_d = '0;
    end else if (force_max) begin
      q_d = max_digit;
    end else if (step) begin
      if (up) q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
      else    q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign tc = up ? (q_q == 4'd9) : (q_q == 4'd0);

endmodule

// File: rtl/bcd_count_mod.sv
// bcd_count_mod
//   Cascadable BCD modulo-MODULUS up/down counter with parallel load.
//   Parameters: NDIGITS (1..4 digits), MODULUS (2..10^NDIGITS).
//   clk, rst  : clock, synchronous active-high reset.
//   en, up    : count enable and direction (1 = up).
//   load      : parallel load of load_val (BCD, digit 0 in [3:0]).
//   count     : current BCD value.
//   co        : combinational carry/borrow; tie to the next stage's en.
//   load_err  : only when BCD_LOAD_CHECK_EN is defined; high for one cycle
//               after a load of a non-BCD or out-of-range value, which is
//               rejected. Without the macro loads are unchecked and an
//               out-of-range count recovers on the next step.
module bcd_count_mod
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 2,
  parameter int MODULUS = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   up,
  input  logic                   load,
  input  logic [BCD_W*NDIGITS-1:0] load_val,
  output logic [BCD_W*NDIGITS-1:0] count,
  output logic                   co
`ifdef BCD_LOAD_CHECK_EN
  ,
  output logic                   load_err
`endif
);

  localparam int W = BCD_W * NDIGITS;

  if (NDIGITS < 1 || NDIGITS > MAX_DIGS || MODULUS < 2 || MODULUS > 10 ** NDIGITS) begin : g_bad_param
    $error("bcd_count_mod: illegal NDIGITS/MODULUS combination");
  end

  localparam logic [MAX_DIGS*BCD_W-1:0] MAX_FULL = bin2bcd(MODULUS - 1, NDIGITS);
  localparam logic [W-1:0]              MAX_BCD  = MAX_FULL[W-1:0];

  logic [W-1:0]         count_int;
  logic [NDIGITS-1:0]   tc;
  logic [NDIGITS-1:0]   chain;
  logic [MAX_DIGS*BCD_W-1:0] count_ext;
  logic [MAX_DIGS*BCD_W-1:0] load_ext;
  logic at_max, all_zero_dn, invalid, adv, load_ok, force_zero, force_max;

  always_comb begin
    count_ext = '0;
    count_ext[W-1:0] = count_int;
    load_ext = '0;
    load_ext[W-1:0] = load_val;
  end

  assign at_max      = (count_int == MAX_BCD);
  // With up=0 every digit flags tc at 0, so the AND is "count is zero".
  assign all_zero_dn = ~up & (&tc);
  // Plain compare on BCD vectors orders correctly once all digits are 0..9.
  assign invalid     = ~bcd_valid(count_ext, NDIGITS) | (count_int > MAX_BCD);

`ifdef BCD_LOAD_CHECK_EN
  assign load_ok = load & bcd_valid(load_ext, NDIGITS) & (load_val <= MAX_BCD);

  logic load_err_q, load_err_d;
  assign load_err_d = load & ~load_ok;
  always_ff @(posedge clk) begin
    if (rst) load_err_q <= 1'b0;
    else     load_err_q <= load_err_d;
  end
  assign load_err = load_err_q;
`else
  assign load_ok = load;
  logic unused_load_ext;
  assign unused_load_ext = ^load_ext;
`endif

  // A load cycle (accepted or rejected) never steps the counter.
  assign adv        = en & ~load & ~rst;
  assign force_zero = adv &  up & (at_max | invalid);
  assign force_max  = adv & ~up & (all_zero_dn | invalid);
  assign co         = adv & ((up & at_max) | all_zero_dn);

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign chain[gi] = adv;
      end else begin : g_rest
        assign chain[gi] = chain[gi-1] & tc[gi-1];
      end

      bcd_digit_updn u_digit (
        .clk        (clk),
        .rst        (rst),
        .step       (chain[gi]),
        .up         (up),
        .load       (load_ok),
        .d          (load_val[gi*BCD_W +: BCD_W]),
        .force_zero (force_zero),
        .force_max  (force_max),
        .max_digit  (MAX_BCD[gi*BCD_W +: BCD_W]),
        .q          (count_int[gi*BCD_W +: BCD_W]),
        .tc         (tc[gi])
      );
    end
  endgenerate

  assign count = count_int;

endmodule
